// File: rtl/xor_stream_pkg.sv
// Shared types and constants for the XOR bit-stream framer.
// The optional XOR_FRAMER_ODD_PARITY_EN macro is consumed by the top-level framer.
package xor_stream_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam int FRAME_LEN_DEFAULT = 4;
    localparam int FRAME_LEN_MAX     = 32;

endpackage

// File: rtl/xor_stream_framer_beat_counter.sv
// Beat counter for the framer: counts accepted beats and flags the one that completes a frame.
// last is combinational with inc so the FSM can leave COLLECT on the same edge.
module framer_beat_counter #(
    parameter int FRAME_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic last
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FRAME_LEN);

    logic [CNT_W-1:0] cnt_q;

    assign last = inc && (cnt_q == LAST_IDX);

    // Saturates at FRAME_LEN; only clr brings it back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != FULL)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/xor_stream_framer.sv
// Collects serial XOR result bits into FRAME_LEN-bit frames with a parity bit on a valid/ready output.
// Define XOR_FRAMER_ODD_PARITY_EN to produce odd parity instead of even parity.
//
// Handshakes: a beat transfers on any rising edge where valid && ready are both high;
// valid never waits on ready, and in_ready is a pure decode of the registered state.
module xor_stream_framer
    import xor_stream_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 x_bit,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FRAME_LEN-1:0] out_data,
    output logic                 out_parity,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output state_t               dbg_state
);

`ifdef XOR_FRAMER_ODD_PARITY_EN
    localparam logic PARITY_INV = 1'b1;
`else
    localparam logic PARITY_INV = 1'b0;
`endif

    state_t               state_q;
    state_t               state_d;
    logic [FRAME_LEN-1:0] shift_q;
    logic [FRAME_LEN-1:0] shift_next;
    logic                 par_q;
    logic                 par_next;
    logic [FRAME_LEN-1:0] out_data_q;
    logic                 out_parity_q;
    logic                 accept;
    logic                 handoff;
    logic                 last_beat;

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    assign accept  = in_valid && in_ready;
    assign handoff = out_valid && out_ready;

    generate
        if (FRAME_LEN == 1) begin : g_single
            assign shift_next = x_bit;
        end else begin : g_multi
            assign shift_next = {shift_q[FRAME_LEN-2:0], x_bit};
        end
    endgenerate

    assign par_next = par_q ^ x_bit;

    framer_beat_counter #(
        .FRAME_LEN (FRAME_LEN)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept),
        .clr   (handoff),
        .last  (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = last_beat ? HOLD : COLLECT;
                end
            end
            COLLECT: begin
                if (accept && last_beat) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Assembly path: cleared on handoff so the next frame starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (handoff) begin
            shift_q <= '0;
            par_q   <= 1'b0;
        end else if (accept) begin
            shift_q <= shift_next;
            par_q   <= par_next;
        end
    end

    // Output frame is captured on the completing beat and kept after the handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_parity_q <= 1'b0;
        end else if (last_beat) begin
            out_data_q   <= shift_next;
            out_parity_q <= par_next ^ PARITY_INV;
        end
    end

    assign out_data   = out_data_q;
    assign out_parity = out_parity_q;

endmodule

// File: tb/tb_xor_stream_framer.sv
// Directed bench for xor_stream_framer: FRAME_LEN=4 and FRAME_LEN=1 instances on a shared clock and reset.
// Expected parity follows XOR_FRAMER_ODD_PARITY_EN when the bench is built with it.
module tb_xor_stream_framer;
    import xor_stream_pkg::*;

`ifdef XOR_FRAMER_ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       x_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic       in_ready, out_parity, out_valid, busy;
    logic [3:0] out_data;
    state_t     dbg_state;

    logic       x1 = 1'b0, v1 = 1'b0, r1 = 1'b0;
    logic       in_ready1, out_parity1, out_valid1, busy1;
    logic [0:0] out_data1;
    state_t     dbg_state1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    xor_stream_framer #(.FRAME_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .x_bit(x_bit), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_parity(out_parity), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .dbg_state(dbg_state)
    );

    xor_stream_framer #(.FRAME_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .x_bit(x1), .in_valid(v1), .in_ready(in_ready1),
        .out_data(out_data1), .out_parity(out_parity1), .out_valid(out_valid1),
        .out_ready(r1), .busy(busy1), .dbg_state(dbg_state1)
    );

    // Packed view {in_ready, out_valid, busy, out_data, out_parity} of the 4-bit instance.
    logic [7:0] obs;
    assign obs = {in_ready, out_valid, busy, out_data, out_parity};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b);
        x_bit = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        tick();
        tests_run++;
        if (obs !== 8'b1_0_0_0000_0) begin
            tests_failed++;
            $display("FAIL reset obs got %b want %b", obs, 8'b1_0_0_0000_0);
        end
        tests_run++;
        if ({in_ready1, out_valid1, busy1, out_data1, out_parity1} !== 5'b1_0_0_0_0) begin
            tests_failed++;
            $display("FAIL reset1 got %b want %b",
                     {in_ready1, out_valid1, busy1, out_data1, out_parity1}, 5'b10000);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp_v;
        out_ready = 1'b1;
        x_bit = 1'b1; in_valid = 1'b1; tick();
        tests_run++;
        if (obs !== 8'b1_0_1_0000_0) begin
            tests_failed++;
            $display("FAIL basic_beat1 got %b want %b", obs, 8'b1_0_1_0000_0);
        end
        x_bit = 1'b0; tick();
        x_bit = 1'b1; tick();
        x_bit = 1'b1; tick();
        in_valid = 1'b0;
        exp_v = {3'b0_1_1, 4'b1011, 1'b1 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL basic_hold got %b want %b", obs, exp_v);
        end
        tick();
        exp_v = {3'b1_0_0, 4'b1011, 1'b1 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL basic_idle got %b want %b", obs, exp_v);
        end
    endtask

    task automatic test_gaps_backpressure();
        logic [7:0] exp_v;
        out_ready = 1'b0;
        beat(1'b1);
        beat(1'b1);
        tick();
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b1_0_1) begin
            tests_failed++;
            $display("FAIL gap_retain got %b want %b", {in_ready, out_valid, busy}, 3'b101);
        end
        beat(1'b0);
        beat(1'b0);
        exp_v = {3'b0_1_1, 4'b1100, 1'b0 ^ ODD};
        for (int i = 0; i < 5; i++) begin
            x_bit = 1'b1;
            in_valid = 1'b1;
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL stall_%0d got %b want %b", i, obs, exp_v);
            end
            tick();
        end
        in_valid = 1'b0;
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL stall_end got %b want %b", obs, exp_v);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({in_ready, out_valid, busy} !== 3'b1_0_0) begin
            tests_failed++;
            $display("FAIL stall_release got %b want %b", {in_ready, out_valid, busy}, 3'b100);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] exp_v;
        out_ready = 1'b1;
        beat(1'b1);
        beat(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({in_ready, out_valid, busy, dbg_state} !== {3'b1_0_0, IDLE}) begin
            tests_failed++;
            $display("FAIL async_reset got %b want %b", {in_ready, out_valid, busy, dbg_state},
                     {3'b100, IDLE});
        end
        #1;
        rst_n = 1'b1;
        x_bit = 1'b0; in_valid = 1'b1; tick();
        x_bit = 1'b1; tick();
        tick();
        tick();
        in_valid = 1'b0;
        exp_v = {3'b0_1_1, 4'b0111, 1'b1 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL post_reset_frame got %b want %b", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_frame_len1();
        r1 = 1'b1;
        x1 = 1'b1; v1 = 1'b1; tick(); v1 = 1'b0;
        tests_run++;
        if ({out_valid1, in_ready1, out_data1, out_parity1} !== {2'b10, 1'b1, 1'b1 ^ ODD}) begin
            tests_failed++;
            $display("FAIL len1_one got %b want %b", {out_valid1, in_ready1, out_data1, out_parity1},
                     {2'b10, 1'b1, 1'b1 ^ ODD});
        end
        tick();
        tests_run++;
        if ({out_valid1, in_ready1, busy1} !== 3'b010) begin
            tests_failed++;
            $display("FAIL len1_idle got %b want %b", {out_valid1, in_ready1, busy1}, 3'b010);
        end
        x1 = 1'b0; v1 = 1'b1; tick(); v1 = 1'b0;
        tests_run++;
        if ({out_valid1, out_data1, out_parity1} !== {1'b1, 1'b0, 1'b0 ^ ODD}) begin
            tests_failed++;
            $display("FAIL len1_zero got %b want %b", {out_valid1, out_data1, out_parity1},
                     {1'b1, 1'b0, 1'b0 ^ ODD});
        end
        tick();
    endtask

    task automatic test_parity_frames();
        logic [7:0] exp_v;
        out_ready = 1'b1;
        x_bit = 1'b0; in_valid = 1'b1; tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        exp_v = {3'b0_1_1, 4'b0000, ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL parity_zero got %b want %b", obs, exp_v);
        end
        tick();
        x_bit = 1'b1; in_valid = 1'b1; tick();
        x_bit = 1'b0; tick(); tick(); tick();
        in_valid = 1'b0;
        exp_v = {3'b0_1_1, 4'b1000, 1'b1 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL parity_1000 got %b want %b", obs, exp_v);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_v;
        out_ready = 1'b1;
        x_bit = 1'b0; in_valid = 1'b1; tick();
        x_bit = 1'b1; tick();
        x_bit = 1'b0; tick();
        x_bit = 1'b1; tick();
        // in_valid stays high: the HOLD cycle must refuse, the IDLE bubble then accepts.
        x_bit = 1'b1;
        exp_v = {3'b0_1_1, 4'b0101, 1'b0 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_first got %b want %b", obs, exp_v);
        end
        tick(); tick(); tick(); tick(); tick();
        in_valid = 1'b0;
        exp_v = {3'b0_1_1, 4'b1111, 1'b0 ^ ODD};
        tests_run++;
        if (obs !== exp_v) begin
            tests_failed++;
            $display("FAIL b2b_second got %b want %b", obs, exp_v);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps_backpressure();
        test_async_reset();
        test_frame_len1();
        test_parity_frames();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/xor_stream_framer.md
Name: xor_stream_framer

Overview:
- Downstream consumer of the 1-bit XOR gate output (X).
- Collects a serial stream of XOR result bits into FRAME_LEN-bit frames, computes frame parity, and presents each frame on a ready/valid output.
- Sits between the 1-bit gate layer and the 4-bit shifter, which takes out_data when FRAME_LEN=4.

Parameters:
- FRAME_LEN, 4, bits per frame; legal range 1..32.
- CNT_W, $clog2(FRAME_LEN+1), beat counter width; derived, not overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- x_bit  in  1  XOR gate result bit (X).
- in_valid  in  1  x_bit is valid this cycle.
- in_ready  out  1  framer accepts x_bit this cycle.
- out_data  out  FRAME_LEN  assembled frame; first-accepted bit in the MSB.
- out_parity  out  1  frame parity bit.
- out_valid  out  1  frame and parity are valid.
- out_ready  in  1  consumer takes the frame.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, cnt=0, shift reg=0, parity acc=0, in_ready=1, out_valid=0, out_data=0, out_parity=0, busy=0.
- Beat acceptance: in_valid && in_ready at a rising clk edge.
- Shift rule: on each accepted beat, shift reg <= {shift reg[FRAME_LEN-2:0], x_bit} and parity acc ^= x_bit.
- State IDLE (in_ready=1):
  - accepted beat -> COLLECT, cnt=1.
  - if FRAME_LEN==1, go straight to HOLD.
- State COLLECT (in_ready=1):
  - accepted beat -> cnt+1.
  - when the accepted beat is beat number FRAME_LEN, go to HOLD.
  - in_valid gaps are allowed; state, cnt and partial data are retained.
- State HOLD (in_ready=0):
  - out_valid=1; out_data and out_parity are registered at the edge that accepted the last beat.
  - out_valid asserts the cycle after the final beat (latency 1).
  - out_data and out_parity stay stable while out_valid=1 and out_ready=0.
  - out_valid && out_ready -> IDLE next edge: out_valid=0, in_ready=1, cnt=0, parity acc=0, shift reg=0.
  - out_data keeps its last value after the handoff.
- No same-cycle accept in HOLD: back-to-back frames have a one-cycle bubble (IDLE re-entry edge) plus any out_ready stall.
- in_ready is a registered/state decode only; it never depends combinationally on out_ready.
- Parity: out_parity = XOR of all FRAME_LEN bits (even parity, so the total ones count including the parity bit is even).
- Boundaries:
  - x_bit is ignored whenever in_ready=0 or in_valid=0.
  - out_ready high with out_valid low has no effect.
  - rst_n low mid-frame or in HOLD discards the partial or pending frame immediately; all outputs go to reset values with no clock required.
  - cnt never exceeds FRAME_LEN; there is no wrap.

Optional Feature:
- Macro: XOR_FRAMER_ODD_PARITY_EN.
- Defined: out_parity = ~(XOR of frame bits), i.e. odd parity (total ones including the parity bit is odd). A zero frame gives out_parity=1.
- Undefined: even parity as above. No other behaviour changes.

Decomposition:
- Package xor_stream_pkg holds:
  - state enum {IDLE, COLLECT, HOLD}, 2-bit encoding.
  - FRAME_LEN_DEFAULT=4.
  - FRAME_LEN_MAX=32.
- Sub-module framer_beat_counter (clk, rst_n, inc, clr, last): CNT_W counter asserting last on the FRAME_LEN-th increment. Shift reg and FSM stay in the top.

Test Plan:
- Reset: hold rst_n=0, pulse clk -> in_ready=1, out_valid=0, out_data=4'b0000, out_parity=0, busy=0.
- Basic frame (FRAME_LEN=4): x_bit 1,0,1,1 on 4 consecutive valid cycles, out_ready=1 -> next cycle out_valid=1, out_data=4'b1011, out_parity=1; IDLE one cycle later.
- Gaps and backpressure: x_bit 1,1,0,0 with in_valid low for 2 cycles between beats 2 and 3, out_ready=0 for 5 cycles -> out_data=4'b1100 and out_parity=0 held stable, in_ready=0 throughout, extra in_valid beats ignored; out_ready=1 -> out_valid drops next edge.
- Async reset mid-frame: accept 1,0 then drop rst_n between edges -> busy=0 and in_ready=1 immediately; the following frame 0,1,1,1 gives out_data=4'b0111, out_parity=1 (no stale bits).
- FRAME_LEN=1: x_bit 1 -> out_data=1'b1, out_parity=1 next cycle; x_bit 0 -> out_parity=0.
- Odd parity build (XOR_FRAMER_ODD_PARITY_EN): frame 0,0,0,0 -> out_parity=1; frame 1,0,0,0 -> out_parity=0.
